// File: rtl/mul_accumulator_if.sv
// Stream bundle for mul_accumulator: burst control, product input and result output.
interface mul_accumulator_if #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [PROD_W-1:0] prod_in;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              out_valid;
  logic              out_ready;
  logic [LEN_W-1:0]  count;
  logic              ovf;
  logic              busy;

  modport master (
    output start, len, prod_in, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, count, ovf, busy
  );

  modport slave (
    input  start, len, prod_in, in_valid, out_ready,
    output in_ready, acc_out, out_valid, count, ovf, busy
  );
endinterface

// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a programmed burst of unsigned products into a wide accumulator.
// Build option SATURATE_EN: clamp the accumulator to all-ones on carry instead of wrapping.
module mul_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int LEN_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  mul_accumulator_if.slave bus
);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             hs;
  logic             last;
  logic [ACC_W:0]   sum;

  assign hs   = (state_q == ACCUM) && bus.in_valid;
  assign last = (cnt_q + LEN_W'(1)) == len_q;
  // bit ACC_W of the sum is the carry out of the accumulator
  assign sum  = {1'b0, acc_q} + SUM_W'(bus.prod_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (hs && last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (1'b1)
      state_q == IDLE:  bus.busy      = 1'b0;
      state_q == ACCUM: bus.in_ready  = 1'b1;
      state_q == DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          len_d = bus.len;
        end
      end
      ACCUM: begin
        if (hs) begin
`ifdef SATURATE_EN
          acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          cnt_d = cnt_q + LEN_W'(1);
          ovf_d = ovf_q | sum[ACC_W];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.acc_out = acc_q;
  assign bus.count   = cnt_q;
  assign bus.ovf     = ovf_q;
endmodule
